frame_reorder: RTL

FRAME_REORDER -- requirements
Module: frame_reorder

---
 rtl/frame_reorder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/frame_reorder.sv
// frame_reorder: ping-pong frame buffer that writes samples in natural order
// and reads them back in one of four permutations (natural, bit-reversed,
// half-interleave, reversed). Each bank is a simple dual-port RAM with a
// registered read port; the read register doubles as the output data stage.
module frame_reorder #(
    parameter int DBW = 16,
    parameter int CBW = 3,
    parameter int CH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DBW*CH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DBW*CH-1:0] out_data,
    output logic              out_first,
    output logic              out_last
);

    localparam int W = DBW * CH;
    localparam int N = 1 << CBW;
    localparam logic [CBW-1:0] LAST_IDX = CBW'(N - 1);

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    bank_state_t    bank_state [2];
    logic           started;
    logic           wr_bank;
    logic           rd_bank;
    logic           out_bank;
    logic [CBW-1:0] wr_cnt;
    logic [CBW-1:0] rd_cnt;
    logic [CBW-1:0] rd_addr;
    logic [1:0]     mode_q;
    logic [1:0]     eff_mode;
    logic           wr_fire;
    logic           rd_start;
    logic           rd_avail;
    logic           rd_en;

    // Maps output index j to the RAM address holding that sample.
    // Half-interleave is a rotate-right by one bit of the index.
    function automatic logic [CBW-1:0] permute(input logic [CBW-1:0] j,
                                               input logic [1:0]     m);
        logic [CBW-1:0] r;
        r = j;
        case (m)
            2'd1: begin
                for (int i = 0; i < CBW; i++) begin
                    r[i] = j[CBW-1-i];
                end
            end
            2'd2: r = {j[0], j[CBW-1:1]};
            2'd3: r = ~j;
            default: r = j;
        endcase
        return r;
    endfunction

    // Handshake decode. A bank that is FULL starts draining on the first read,
    // and the mode for that frame is taken straight from the port on that cycle
    // so the first address already honours it. A bank is released as soon as
    // its last word has been read into the output register, which is what lets
    // the writer roll straight into it with no bubble.
    always_comb begin
        in_ready = started &&
                   ((bank_state[wr_bank] == BANK_FREE) ||
                    (bank_state[wr_bank] == BANK_FILLING));
        wr_fire  = in_valid && in_ready;
        rd_start = (bank_state[rd_bank] == BANK_FULL);
        rd_avail = rd_start || (bank_state[rd_bank] == BANK_DRAINING);
        rd_en    = rd_avail && (!out_valid || out_ready);
        eff_mode = rd_start ? mode : mode_q;
        rd_addr  = permute(rd_cnt, eff_mode);
    end

    // Write/read pointers, sample counters and the per-frame mode latch.
    // Counters are exactly CBW bits wide, so they wrap to 0 at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            mode_q  <= '0;
        end else begin
            started <= 1'b1;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LAST_IDX) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_start) begin
                    mode_q <= mode;
                end
                if (rd_cnt == LAST_IDX) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    // Bank state machine. The writer only touches FREE/FILLING banks and the
    // reader only FULL/DRAINING ones, so the two events never hit one bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state[0] <= BANK_FREE;
            bank_state[1] <= BANK_FREE;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_fire && (wr_bank == 1'(b))) begin
                    bank_state[b] <= (wr_cnt == LAST_IDX) ? BANK_FULL : BANK_FILLING;
                end else if (rd_en && (rd_bank == 1'(b))) begin
                    bank_state[b] <= (rd_cnt == LAST_IDX) ? BANK_FREE : BANK_DRAINING;
                end
            end
        end
    end

    // Output flags advance together with the RAM read register so that the
    // data, first and last markers all hold while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_bank  <= 1'b0;
        end else if (rd_en) begin
            out_valid <= 1'b1;
            out_first <= (rd_cnt == '0);
            out_last  <= (rd_cnt == LAST_IDX);
            out_bank  <= rd_bank;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [W-1:0] mem [N];
        logic [W-1:0] rd_q;

        // Write port: natural-order fill of this bank.
        always_ff @(posedge clk) begin
            if (wr_fire && (wr_bank == 1'(b))) begin
                mem[wr_cnt] <= in_data;
            end
        end

        // Registered read port with enable; holding it is the stall mechanism.
        always_ff @(posedge clk) begin
            if (rd_en && (rd_bank == 1'(b))) begin
                rd_q <= mem[rd_addr];
            end
        end
    end

    assign out_data = out_bank ? g_bank[1].rd_q : g_bank[0].rd_q;

endmodule
